// File: rtl/led_pattern_sequencer.sv
// LED pattern scheduler: steps 8 LEDs through run-up, run-down, ping-pong or blink
// at a prescaled rate, with start/stop/pause control and optional auto-stop.
module led_pattern_sequencer #(
  parameter int unsigned N_LED  = 8,
  parameter int unsigned DIV    = 25_000_000,
  parameter int unsigned REPEAT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             step,
  output logic             done
);

  localparam int unsigned IW = $clog2(N_LED);
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned SW = $clog2(REPEAT + 2);

  localparam logic [PW-1:0] PRE_MAX    = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(N_LED - 1);
  localparam logic [IW-1:0] IDX_BOUNCE = IW'(N_LED - 2);
  localparam logic [SW-1:0] LAST_SWEEP = SW'((REPEAT == 0) ? 0 : REPEAT - 1);
  localparam bit            HAS_REPEAT = (REPEAT != 0);

  localparam logic [1:0] M_UP    = 2'd0;
  localparam logic [1:0] M_DOWN  = 2'd1;
  localparam logic [1:0] M_PING  = 2'd2;
  localparam logic [1:0] M_BLINK = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [PW-1:0]   pre;
  logic [IW-1:0]   idx;
  logic            dir;
  logic [SW-1:0]   sweep;

  logic [IW-1:0]    adv_idx;
  logic             adv_dir;
  logic [N_LED-1:0] adv_led;
  logic             adv_wrap;
  logic             last_sweep;

  function automatic logic [IW-1:0] start_idx(input logic [1:0] m);
    return (m == M_DOWN) ? IDX_MAX : '0;
  endfunction

  function automatic logic [N_LED-1:0] start_led(input logic [1:0] m);
    logic [N_LED-1:0] v;
    v = (m == M_BLINK) ? '1 : (N_LED'(1) << start_idx(m));
    return v;
  endfunction

  // Next pattern position and whether it lands back on the mode's start value
  always_comb begin
    adv_idx  = idx;
    adv_dir  = dir;
    adv_led  = led;
    adv_wrap = 1'b0;
    case (mode_q)
      M_UP: begin
        adv_idx  = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        adv_led  = N_LED'(1) << adv_idx;
        adv_wrap = (adv_idx == '0);
      end
      M_DOWN: begin
        adv_idx  = (idx == '0) ? IDX_MAX : idx - IW'(1);
        adv_led  = N_LED'(1) << adv_idx;
        adv_wrap = (adv_idx == IDX_MAX);
      end
      M_PING: begin
        if (dir) begin
          if (idx == IDX_MAX) begin
            adv_idx = IDX_BOUNCE;
            adv_dir = 1'b0;
          end else begin
            adv_idx = idx + IW'(1);
          end
        end else begin
          if (idx == '0) begin
            adv_idx = IW'(1);
            adv_dir = 1'b1;
          end else begin
            adv_idx = idx - IW'(1);
          end
        end
        adv_led  = N_LED'(1) << adv_idx;
        adv_wrap = (adv_idx == '0);
      end
      M_BLINK: begin
        adv_led  = ~led;
        adv_wrap = (led == '0);
      end
    endcase
    last_sweep = HAS_REPEAT && (sweep == LAST_SWEEP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      led    <= '0;
      busy   <= 1'b0;
      step   <= 1'b0;
      done   <= 1'b0;
      pre    <= '0;
      idx    <= '0;
      dir    <= 1'b0;
      sweep  <= '0;
      mode_q <= M_UP;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          led  <= '0;
          pre  <= '0;
          busy <= 1'b0;
          if (start && !stop) begin
            state  <= RUN;
            busy   <= 1'b1;
            mode_q <= mode;
            sweep  <= '0;
            idx    <= start_idx(mode);
            dir    <= 1'b1;
            led    <= start_led(mode);
          end
        end
        RUN, PAUSE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            led   <= '0;
            pre   <= '0;
          end else if (pause) begin
            state <= PAUSE;
          end else begin
            // Releasing pause counts in the same cycle, so the step slips by exactly the paused time
            state <= RUN;
            if (pre == PRE_MAX) begin
              pre  <= '0;
              step <= 1'b1;
              if (mode != mode_q) begin
                mode_q <= mode;
                sweep  <= '0;
                idx    <= start_idx(mode);
                dir    <= 1'b1;
                led    <= start_led(mode);
              end else begin
                idx <= adv_idx;
                dir <= adv_dir;
                led <= adv_led;
                if (adv_wrap) begin
                  if (sweep != '1) sweep <= sweep + SW'(1);
                  if (last_sweep) begin
                    done  <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                end
              end
            end else begin
              pre <= pre + PW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
